imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 127 ++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extractor/extender with valid/ready flow control.
// Ports: clk, rst_n, in_valid/in_ready/in_instr/in_mode, flush, cnt_clr,
//   out_valid/out_ready/out_imm/out_err, err_cnt (saturating error count).
module imm_extend_pipe #(
  parameter int DATA_W     = 64,
  parameter int BR_SHIFT   = 2,
  parameter bit SHIFT12_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [2:0]        in_mode,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  mode;
  } s1_t;

  s1_t  s1;
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic s1_adv;
  logic s1_load;

  logic [63:0] imm64;
  logic        err_c;
  logic        unused;

  assign unused = ^s1.instr[31:26];

  assign s2_load   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_load;
  assign s1_load   = !s1_valid || s1_adv;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_comb begin
    imm64 = '0;
    err_c = 1'b0;
    unique case (1'b1)
      (s1.mode == 3'd0): begin
        imm64 = {52'd0, s1.instr[21:10]};
        if (SHIFT12_EN && s1.instr[22])
          imm64 = imm64 << 12;
      end
      (s1.mode == 3'd1): begin
        imm64 = {{55{s1.instr[20]}},
                 s1.instr[20:12]};
      end
      (s1.mode == 3'd2): begin
        imm64 = {{38{s1.instr[25]}},
                 s1.instr[25:0]} << BR_SHIFT;
      end
      (s1.mode == 3'd3): begin
        imm64 = {{45{s1.instr[23]}},
                 s1.instr[23:5]} << BR_SHIFT;
      end
      (s1.mode == 3'd4): begin
        imm64 = {48'd0, s1.instr[20:5]}
                << {s1.instr[22:21], 4'd0};
        // A 32-bit result cannot hold hw=2/3.
        if (DATA_W == 32 && s1.instr[22]) begin
          imm64 = '0;
          err_c = 1'b1;
        end
      end
      default: begin
        imm64 = '0;
        err_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      out_imm  <= '0;
      out_err  <= 1'b0;
    end else begin
      if (flush)
        s1_valid <= 1'b0;
      else if (s1_load)
        s1_valid <= in_valid;

      if (s1_load && in_valid) begin
        s1.instr <= in_instr;
        s1.mode  <= in_mode;
      end

      if (flush)
        s2_valid <= 1'b0;
      else if (s2_load)
        s2_valid <= s1_valid;

      // Data only moves with a real result, so it
      // holds while stalled.
      if (s1_adv) begin
        out_imm <= imm64[DATA_W-1:0];
        out_err <= err_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= 8'd0;
    else if (cnt_clr)
      err_cnt <= 8'd0;
    else if (out_valid && out_ready && out_err
             && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end

endmodule
